// File: rtl/risc_pkg.sv
// Shared EX-stage widths, ALU/func encodings, FSM states and control bundle.
// EX_DIVIDER_EN adds the DIV_BUSY state used by the iterative divider.
package risc_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_RTYPE = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SLT   = 3'b101
    } alu_op_e;

    typedef enum logic [3:0] {
        F_ADD = 4'b0000,
        F_SUB = 4'b0001,
        F_AND = 4'b0010,
        F_OR  = 4'b0011,
        F_NOR = 4'b0100,
        F_SLT = 4'b0101,
        F_MUL = 4'b0110,
        F_DIV = 4'b0111
    } func_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
`ifdef EX_DIVIDER_EN
        DIV_BUSY = 2'd2,
`endif
        DONE     = 2'd3
    } state_e;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctrl_t;

endpackage

// File: rtl/ex_stage_if.sv
// Start/busy/done handshake between the EX stage and the iterative mul/div.
// EX_DIVIDER_EN adds the is_div select.
interface ex_stage_if #(
    parameter int WIDTH = 16
);
    logic             start;
`ifdef EX_DIVIDER_EN
    logic             is_div;
`endif
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
`ifdef EX_DIVIDER_EN
        output is_div,
`endif
        output start, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
`ifdef EX_DIVIDER_EN
        input  is_div,
`endif
        input  start, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier, one bit per falling edge, WIDTH iterations.
// EX_DIVIDER_EN adds a restoring unsigned divider sharing the same registers.
module iter_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  md
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
`ifdef EX_DIVIDER_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
`endif

    // a: multiplier / dividend->quotient, b: multiplicand / divisor
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
`ifdef EX_DIVIDER_EN
        div_d   = div_q;
        shifted = {acc_q, a_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
`endif
        if (md.start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            a_d    = md.op_a;
            b_d    = md.op_b;
            acc_d  = '0;
`ifdef EX_DIVIDER_EN
            div_d  = md.is_div;
`endif
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
`ifdef EX_DIVIDER_EN
            if (div_q) begin
                if (!diff[WIDTH]) begin
                    acc_d = diff[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                end
            end else
`endif
            begin
                acc_d = acc_q + (a_q[0] ? b_q : '0);
                a_d   = a_q >> 1;
                b_d   = b_q << 1;
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
`ifdef EX_DIVIDER_EN
            div_q  <= 1'b0;
`endif
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
`ifdef EX_DIVIDER_EN
            div_q  <= div_d;
`endif
        end
    end

    assign md.busy = busy_q;
    assign md.done = busy_q && (cnt_q == LAST);
`ifdef EX_DIVIDER_EN
    assign md.result = div_q ? a_q : acc_q;
`else
    assign md.result = acc_q;
`endif

endmodule

// File: rtl/ex_stage.sv
// EX stage: ALU, stall FSM for iterative mul/div, falling-edge EX/MEM register.
// Define EX_DIVIDER_EN to make func 0111 a multi-cycle unsigned divide.
module ex_stage #(
    parameter int WIDTH = risc_pkg::WIDTH
) (
    input  logic             inp_clk,
    input  logic             inp_rst_n,
    input  logic [3:0]       inp_func,
    input  logic [2:0]       inp_aluOp,
    input  logic [WIDTH-1:0] inp_address,
    input  logic [WIDTH-1:0] inp_data1,
    input  logic [WIDTH-1:0] inp_data2,
    input  logic [WIDTH-1:0] inp_immdate,
    input  logic [2:0]       inp_rt,
    input  logic [2:0]       inp_rd,
    input  logic             inp_regDst,
    input  logic             inp_aluSrc,
    input  logic             inp_memToReg,
    input  logic             inp_regWrite,
    input  logic             inp_memRead,
    input  logic             inp_memWrite,
    input  logic             inp_branch,
    output logic             out_hit,
    output logic [WIDTH-1:0] out_aluResult,
    output logic [WIDTH-1:0] out_writeData,
    output logic [WIDTH-1:0] out_branchTarget,
    output logic [2:0]       out_writeReg,
    output logic             out_zero,
    output logic             out_memToReg,
    output logic             out_regWrite,
    output logic             out_memRead,
    output logic             out_memWrite,
    output logic             out_branch
);
    import risc_pkg::*;

    ex_stage_if #(.WIDTH(WIDTH)) md_if ();

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (inp_clk),
        .rst_n (inp_rst_n),
        .md    (md_if.slave)
    );

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_b, alu_res, btgt_in;
    logic [2:0]       wreg_in;
    ctrl_t            ctrl_in;
    logic             mul_req, div_req, start, hit;

    logic [WIDTH-1:0] res_q, res_d, wdata_q, wdata_d, btgt_q, btgt_d;
    logic [2:0]       wreg_q, wreg_d;
    logic             zero_q, zero_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [WIDTH-1:0] hold_wdata_q, hold_wdata_d, hold_btgt_q, hold_btgt_d;
    logic [2:0]       hold_wreg_q, hold_wreg_d;
    ctrl_t            hold_ctrl_q, hold_ctrl_d;

    assign op_b    = inp_aluSrc ? inp_immdate : inp_data2;
    assign wreg_in = inp_regDst ? inp_rd : inp_rt;
    assign btgt_in = inp_address + inp_immdate;
    assign ctrl_in = '{inp_memToReg, inp_regWrite, inp_memRead,
                       inp_memWrite, inp_branch};

    assign mul_req = (inp_aluOp == ALU_RTYPE) && (inp_func == F_MUL);
`ifdef EX_DIVIDER_EN
    assign div_req = (inp_aluOp == ALU_RTYPE) && (inp_func == F_DIV);
`else
    assign div_req = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        unique case (alu_op_e'(inp_aluOp))
            ALU_ADD: alu_res = inp_data1 + op_b;
            ALU_SUB: alu_res = inp_data1 - op_b;
            ALU_AND: alu_res = inp_data1 & op_b;
            ALU_OR:  alu_res = inp_data1 | op_b;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}},
                                $signed(inp_data1) < $signed(op_b)};
            ALU_RTYPE: begin
                unique case (func_e'(inp_func))
                    F_ADD:        alu_res = inp_data1 + op_b;
                    F_SUB:        alu_res = inp_data1 - op_b;
                    F_AND:        alu_res = inp_data1 & op_b;
                    F_OR:         alu_res = inp_data1 | op_b;
                    F_NOR:        alu_res = ~(inp_data1 | op_b);
                    F_SLT:        alu_res = {{(WIDTH-1){1'b0}},
                                             $signed(inp_data1) < $signed(op_b)};
                    F_MUL, F_DIV: alu_res = '0;
                    default:      alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    always_ff @(negedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Busy states fall back to IDLE if the unit ever drops busy without done
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mul_req) state_d = MUL_BUSY;
`ifdef EX_DIVIDER_EN
                else if (div_req) state_d = DIV_BUSY;
`endif
            end
`ifdef EX_DIVIDER_EN
            MUL_BUSY, DIV_BUSY: begin
`else
            MUL_BUSY: begin
`endif
                if (md_if.done)       state_d = DONE;
                else if (!md_if.busy) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hit   = 1'b1;
        start = 1'b0;
        unique case (1'b1)
            state_q == IDLE: begin
                start = mul_req || div_req;
                hit   = !start;
            end
            state_q == DONE: hit = 1'b1;
            default:         hit = 1'b0;
        endcase
    end

    assign md_if.start = start;
    assign md_if.op_a  = inp_data1;
    assign md_if.op_b  = op_b;
`ifdef EX_DIVIDER_EN
    assign md_if.is_div = div_req;
`endif

    always_comb begin
        hold_wdata_d = hold_wdata_q;
        hold_btgt_d  = hold_btgt_q;
        hold_wreg_d  = hold_wreg_q;
        hold_ctrl_d  = hold_ctrl_q;
        if (start) begin
            hold_wdata_d = inp_data2;
            hold_btgt_d  = btgt_in;
            hold_wreg_d  = wreg_in;
            hold_ctrl_d  = ctrl_in;
        end
        res_d   = res_q;
        zero_d  = zero_q;
        wdata_d = wdata_q;
        btgt_d  = btgt_q;
        wreg_d  = wreg_q;
        ctrl_d  = ctrl_q;
        if (!hit) begin
            ctrl_d.reg_write = 1'b0;
            ctrl_d.mem_read  = 1'b0;
            ctrl_d.mem_write = 1'b0;
            ctrl_d.branch    = 1'b0;
        end else if (state_q == DONE) begin
            res_d   = md_if.result;
            zero_d  = (md_if.result == '0);
            wdata_d = hold_wdata_q;
            btgt_d  = hold_btgt_q;
            wreg_d  = hold_wreg_q;
            ctrl_d  = hold_ctrl_q;
        end else begin
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            wdata_d = inp_data2;
            btgt_d  = btgt_in;
            wreg_d  = wreg_in;
            ctrl_d  = ctrl_in;
        end
    end

    always_ff @(negedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            res_q        <= '0;
            zero_q       <= 1'b0;
            wdata_q      <= '0;
            btgt_q       <= '0;
            wreg_q       <= '0;
            ctrl_q       <= '0;
            hold_wdata_q <= '0;
            hold_btgt_q  <= '0;
            hold_wreg_q  <= '0;
            hold_ctrl_q  <= '0;
        end else begin
            res_q        <= res_d;
            zero_q       <= zero_d;
            wdata_q      <= wdata_d;
            btgt_q       <= btgt_d;
            wreg_q       <= wreg_d;
            ctrl_q       <= ctrl_d;
            hold_wdata_q <= hold_wdata_d;
            hold_btgt_q  <= hold_btgt_d;
            hold_wreg_q  <= hold_wreg_d;
            hold_ctrl_q  <= hold_ctrl_d;
        end
    end

    assign out_hit          = hit;
    assign out_aluResult    = res_q;
    assign out_zero         = zero_q;
    assign out_writeData    = wdata_q;
    assign out_branchTarget = btgt_q;
    assign out_writeReg     = wreg_q;
    assign out_memToReg     = ctrl_q.mem_to_reg;
    assign out_regWrite     = ctrl_q.reg_write;
    assign out_memRead      = ctrl_q.mem_read;
    assign out_memWrite     = ctrl_q.mem_write;
    assign out_branch       = ctrl_q.branch;

endmodule
